// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file write port.
// After reset it clears x1..x(REG_COUNT-1) to zero. It then arbitrates two
// writeback requesters: req0 is the ALU and req1 is the load unit.
//
//   state | meaning
//   INIT  | clear sweep in progress; one write per cycle; both readies held low
//   RUN   | arbitrate requesters; at most one accepted write per cycle
module rf_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int REG_COUNT = 32,
  parameter int RR_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last;     // index of the most recently accepted requester
  logic              grant0;
  logic              grant1;

  // Pick at most one requester. On contention, round-robin favours the
  // requester that was not accepted last; fixed priority always favours req0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (RR_EN != 0 && !last) grant1 = 1'b1;
      else                     grant0 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Readies are masked by rst, so no handshake can complete in a reset cycle.
  assign req0_ready = (state == RUN) && grant0 && !rst;
  assign req1_ready = (state == RUN) && grant1 && !rst;
  assign init_done  = (state == RUN);

  // Clear sweep, then register the accepted write onto the regfile port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= ADDR_W'(1);
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          rf_we    <= 1'b1;
          rf_waddr <= cnt;
          rf_wdata <= '0;
          cnt      <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR) state <= RUN;
        end
        RUN: begin
          if (req0_ready) begin
            last     <= 1'b0;
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
            // A write to x0 still consumes the grant but never reaches the regfile.
            rf_we    <= (req0_addr != '0);
          end else if (req1_ready) begin
            last     <= 1'b1;
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
            rf_we    <= (req1_addr != '0);
          end else begin
            rf_we    <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter. Two instances (round-robin and fixed priority)
// each get their own requester stimulus and are checked every cycle against
// a cycle-level reference model of the write-port behaviour.
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           v0, v1;
  logic [1:0][AW-1:0]   a0, a1;
  logic [1:0][DW-1:0]   d0, d1;
  logic [1:0]           rdy0, rdy1, we, idone;
  logic [1:0][AW-1:0]   waddr;
  logic [1:0][DW-1:0]   wdata;

  int errors = 0;
  int checks = 0;

  // Reference model, one slot per instance (0 = round-robin, 1 = fixed priority).
  int          sweep  [2];   // clear writes issued since reset
  int          last_m [2];
  int          gnt    [2];   // requester accepted this cycle, -1 for none
  logic        e_we   [2];
  logic [AW-1:0] e_waddr [2];
  logic [DW-1:0] e_wdata [2];

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .REG_COUNT(RC), .RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
    .rf_we(we[0]), .rf_waddr(waddr[0]), .rf_wdata(wdata[0]), .init_done(idone[0])
  );

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .REG_COUNT(RC), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
    .rf_we(we[1]), .rf_waddr(waddr[1]), .rf_wdata(wdata[1]), .init_done(idone[1])
  );

  task automatic chk(input string tag, input int d, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    sweep[d]   = 0;
    last_m[d]  = 1;
    e_we[d]    = 1'b0;
    e_waddr[d] = '0;
    e_wdata[d] = '0;
  endtask

  // One clock cycle: check at negedge, advance the model at posedge.
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || sweep[d] < RC - 1)  gnt[d] = -1;
      else if (v0[d] && v1[d])       gnt[d] = (d == 0) ? ((last_m[d] == 0) ? 1 : 0) : 0;
      else if (v0[d])                gnt[d] = 0;
      else if (v1[d])                gnt[d] = 1;
      else                           gnt[d] = -1;
      chk("req0_ready", d, DW'(rdy0[d]), DW'(gnt[d] == 0));
      chk("req1_ready", d, DW'(rdy1[d]), DW'(gnt[d] == 1));
      chk("rf_we",      d, DW'(we[d]),    DW'(e_we[d]));
      chk("rf_waddr",   d, DW'(waddr[d]), DW'(e_waddr[d]));
      chk("rf_wdata",   d, wdata[d],      e_wdata[d]);
      chk("init_done",  d, DW'(idone[d]), DW'(sweep[d] == RC - 1));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset(d);
      end else if (sweep[d] < RC - 1) begin
        e_we[d]    = 1'b1;
        e_waddr[d] = AW'(sweep[d] + 1);
        e_wdata[d] = '0;
        sweep[d]++;
      end else if (gnt[d] == 0) begin
        last_m[d]  = 0;
        e_waddr[d] = a0[d];
        e_wdata[d] = d0[d];
        e_we[d]    = (a0[d] != 0);
      end else if (gnt[d] == 1) begin
        last_m[d]  = 1;
        e_waddr[d] = a1[d];
        e_wdata[d] = d1[d];
        e_we[d]    = (a1[d] != 0);
      end else begin
        e_we[d]    = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set0(input logic v, input int a, input logic [DW-1:0] dat);
    for (int d = 0; d < 2; d++) begin
      v0[d] = v; a0[d] = AW'(a); d0[d] = dat;
    end
  endtask

  task automatic set1(input logic v, input int a, input logic [DW-1:0] dat);
    for (int d = 0; d < 2; d++) begin
      v1[d] = v; a1[d] = AW'(a); d1[d] = dat;
    end
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, 0, '0);
    set1(1'b0, 0, '0);
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      gnt[d] = -1;
    end
    @(posedge clk);
    #1;

    // Reset held two cycles, then the full clear sweep and a little idle.
    cyc();
    cyc();
    rst = 1'b0;
    repeat (RC + 2) cyc();

    // Single ALU write.
    set0(1'b1, 5, 32'hDEADBEEF);
    cyc();
    set0(1'b0, 0, '0);
    cyc();
    cyc();

    // Single load-unit write, so the next contention starts with req0.
    set1(1'b1, 2, 32'h55);
    cyc();
    set1(1'b0, 0, '0);

    // Contention for four cycles, valids re-presented after each accept.
    set0(1'b1, 3, 32'hA3);
    set1(1'b1, 7, 32'hB7);
    repeat (4) cyc();
    set0(1'b0, 0, '0);
    set1(1'b0, 0, '0);
    cyc();

    // Write to x0 consumes a grant, then a normal write follows.
    set1(1'b1, 0, 32'h1234);
    cyc();
    set1(1'b0, 0, '0);
    set0(1'b1, 9, 32'h99);
    cyc();
    set0(1'b0, 0, '0);
    cyc();

    // Reset during RUN with a pending request held across the sweep.
    set0(1'b1, 4, 32'h44);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (RC + 1) cyc();
    set0(1'b0, 0, '0);
    cyc();

    // Accept, then reset on the following cycle; then reset mid-sweep.
    set0(1'b1, 6, 32'h66);
    cyc();
    set0(1'b0, 0, '0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (RC + 1) cyc();

    // Randomized requesters that hold their request until accepted.
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        if (!v0[d] || gnt[d] == 0) begin
          v0[d] = ($urandom_range(0, 9) < 6);
          a0[d] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, RC - 1));
          d0[d] = $urandom;
        end
        if (!v1[d] || gnt[d] == 1) begin
          v1[d] = ($urandom_range(0, 9) < 6);
          a1[d] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, RC - 1));
          d1[d] = $urandom;
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
